edge_event_arbiter: RTL
=======================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter: N_CH, default 4, number of input channels (2..16).
REQ-002 Parameter: CW, default $clog2(N_CH), width of the channel index.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: D  input  N_CH  level inputs, one per channel, synchronous to clk.
REQ-006 Port: mode  input  2*N_CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-007 Port: evt_valid  output  1  an event is presented.
REQ-008 Port: evt_ready  input  1  consumer accepts the event.
REQ-009 Port: evt_chan  output  CW  channel index of the presented event.
REQ-010 Port: evt_rise  output  1  polarity of the presented event: 1 rising, 0 falling.
REQ-011 Port: pending  output  N_CH  per-channel pending flags.
REQ-012 Port: ovf  output  N_CH  per-channel sticky overflow flags.
REQ-013 Port: ovf_clr  input  N_CH  per-channel overflow clear, one-cycle pulse.

Function
REQ-014 Each channel registers D[i] into d_q[i] every cycle.
REQ-015 rise[i] = D[i] & ~d_q[i]; fall[i] = ~D[i] & d_q[i]; both are evaluated combinationally in the same cycle.
REQ-016 An event for channel i is qualified when (rise[i] & mode[2i]) | (fall[i] & mode[2i+1]); mode 00 suppresses all events.
REQ-017 A qualified event with pending[i]=0 sets pending[i]=1 and stores pol[i]=rise[i] at the next clock edge.
REQ-018 A qualified event with pending[i]=1 that is not being granted this cycle is dropped: pending and pol are unchanged, and ovf[i] is set.
REQ-019 A qualified event arriving in the same cycle that channel i is granted sets pending[i]=1 with the new polarity; ovf is not set.
REQ-020 The output slot has two states: EMPTY (evt_valid=0) and FULL (evt_valid=1).
REQ-021 A grant occurs in a cycle where pending is nonzero and the slot is EMPTY, or the slot is FULL with evt_ready=1.
REQ-022 On a grant, at the next edge: the slot loads evt_chan=g and evt_rise=pol[g], pending[g] clears (unless REQ-019 applies), the slot is FULL, and last=g.
REQ-023 FULL with evt_ready=1 and no pending channel: the slot goes EMPTY at the next edge.
REQ-024 FULL with evt_ready=0: evt_valid, evt_chan and evt_rise hold stable (no change until accepted).
REQ-025 g is the first set pending bit, searching round-robin from last+1 modulo N_CH; after reset, last=N_CH-1, so channel 0 has first priority.
REQ-026 Latency: an input edge sampled at edge k gives pending at k+1 and evt_valid at k+2 when the slot is free.
REQ-027 Throughput: one event per cycle while evt_ready=1 and events are pending.
REQ-028 ovf_clr[i] clears ovf[i]; if a set condition occurs in the same cycle, the set wins.
REQ-029 Changing mode affects only future qualification; existing pending flags are kept.

Reset
REQ-030 While reset=1, at each clk edge: d_q<=D (no spurious edge on release), pending=0, pol=0, ovf=0, slot EMPTY, evt_chan=0, evt_rise=0, last=N_CH-1.
REQ-031 Reset asserted mid-transaction discards the presented event and all pending events; evt_valid=0 from the first edge with reset=1.
REQ-032 In the first cycle after reset release, no event is generated unless D differs from its value at the last reset edge.

Verification
REQ-033 Single edge: mode=01 on channel 0, evt_ready=1, D[0] 0->1 -> exactly one evt_valid pulse, evt_chan=0, evt_rise=1, at 2 cycles latency.
REQ-034 Both-edge mode: mode=11 on channel 2, D[2] high for 3 cycles -> two events, evt_rise=1 then evt_rise=0, evt_chan=2 for both.
REQ-035 Round-robin: all 4 channels rise together with evt_ready=1 -> events in channel order 0,1,2,3, one per cycle; a repeat burst continues from channel 0 after 3.
REQ-036 Backpressure and overflow: evt_ready=0, channel 1 toggles twice -> evt_valid held on channel 1 with stable fields, ovf[1]=1, later events dropped; ovf_clr[1] clears ovf[1].
REQ-037 Reset: D=4'hF held through reset and released -> no events; reset asserted while evt_valid=1 -> evt_valid=0 and pending=0 at the next edge.
REQ-038 Same-cycle grant and new edge: a channel's pending is granted while the same channel edges -> pending stays 1 with the new polarity and ovf stays 0.

Source files
------------

// File: rtl/edge_event_arbiter_if.sv
// Event output handshake between the edge arbiter (master) and its consumer (slave).
// The slot holds evt_chan/evt_rise stable while evt_valid=1 and evt_ready=0.
interface edge_event_arbiter_if #(
    parameter int CW = 2
);
    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] evt_chan;
    logic          evt_rise;

    modport master (
        output evt_valid,
        output evt_chan,
        output evt_rise,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_chan,
        input  evt_rise,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detector with a one-deep pending flag per channel, feeding a
// single round-robin-arbitrated output slot with valid/ready backpressure.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      D,
    input  logic [2*N_CH-1:0]    mode,
    edge_event_arbiter_if.master evt,
    output logic [N_CH-1:0]      pending,
    output logic [N_CH-1:0]      ovf,
    input  logic [N_CH-1:0]      ovf_clr
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e           slot_q;
    logic [CW-1:0]   chan_q;
    logic            rise_q;
    logic [CW-1:0]   last_q;
    logic [N_CH-1:0] d_q;
    logic [N_CH-1:0] pending_q;
    logic [N_CH-1:0] pol_q;
    logic [N_CH-1:0] ovf_q;

    logic [N_CH-1:0] pending_d;
    logic [N_CH-1:0] pol_d;
    logic [N_CH-1:0] ovf_d;

    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] fall_w;
    logic [N_CH-1:0] qual_w;
    logic [N_CH-1:0] gnt_w;

    logic            grant_found;
    logic [CW-1:0]   grant_idx;
    logic            grant_en;

    // Round-robin search starting just after the most recently granted channel.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last_q) + k) % N_CH;
            if (!grant_found && pending_q[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CW'(idx);
            end
        end
    end

    assign grant_en = grant_found && ((slot_q == SLOT_EMPTY) || evt.evt_ready);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign rise_w[gi] = D[gi] & ~d_q[gi];
            assign fall_w[gi] = ~D[gi] & d_q[gi];
            assign qual_w[gi] = (rise_w[gi] & mode[2*gi]) | (fall_w[gi] & mode[2*gi+1]);
            assign gnt_w[gi]  = grant_en && (grant_idx == CW'(gi));

            // A new edge may refill the flag in the very cycle it is granted;
            // only an edge hitting an occupied, non-granted flag is lost.
            assign pending_d[gi] = (qual_w[gi] && (!pending_q[gi] || gnt_w[gi])) ? 1'b1 :
                                   (gnt_w[gi] ? 1'b0 : pending_q[gi]);
            assign pol_d[gi]     = (qual_w[gi] && (!pending_q[gi] || gnt_w[gi])) ? rise_w[gi] :
                                   pol_q[gi];
            assign ovf_d[gi]     = (qual_w[gi] && pending_q[gi] && !gnt_w[gi]) |
                                   (ovf_q[gi] & ~ovf_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        // D keeps being sampled during reset so release never fabricates an edge.
        d_q <= D;
        if (reset) begin
            pending_q <= '0;
            pol_q     <= '0;
            ovf_q     <= '0;
            slot_q    <= SLOT_EMPTY;
            chan_q    <= '0;
            rise_q    <= 1'b0;
            last_q    <= CW'(N_CH - 1);
        end else begin
            pending_q <= pending_d;
            pol_q     <= pol_d;
            ovf_q     <= ovf_d;
            case (slot_q)
                SLOT_EMPTY: begin
                    if (grant_en) begin
                        slot_q <= SLOT_FULL;
                        chan_q <= grant_idx;
                        rise_q <= pol_q[grant_idx];
                        last_q <= grant_idx;
                    end
                end
                SLOT_FULL: begin
                    if (grant_en) begin
                        chan_q <= grant_idx;
                        rise_q <= pol_q[grant_idx];
                        last_q <= grant_idx;
                    end else if (evt.evt_ready) begin
                        slot_q <= SLOT_EMPTY;
                    end
                end
                default: slot_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign evt.evt_valid = (slot_q == SLOT_FULL);
    assign evt.evt_chan  = chan_q;
    assign evt.evt_rise  = rise_q;
    assign pending       = pending_q;
    assign ovf           = ovf_q;

endmodule
